// File: rtl/pcm_to_i2s_converter_if.sv
// pcm_to_i2s_converter_if: PCM strobe/data inputs and I2S serial outputs of the transmit path
// master: the converter (takes PCM words, drives bclk/lrclk/i2s_data/sample_req/underrun)
// slave: the PCM source and DAC side
interface pcm_to_i2s_converter_if #(
  parameter int num_of_sample_bits = 24
);
  logic l_din_valid;
  logic r_din_valid;
  logic [num_of_sample_bits-1:0] l_pcm_data;
  logic [num_of_sample_bits-1:0] r_pcm_data;
  logic bclk;
  logic lrclk;
  logic i2s_data;
  logic sample_req;
  logic underrun;
  modport master (
    input  l_din_valid, r_din_valid, l_pcm_data, r_pcm_data,
    output bclk, lrclk, i2s_data, sample_req, underrun
  );
  modport slave (
    output l_din_valid, r_din_valid, l_pcm_data, r_pcm_data,
    input  bclk, lrclk, i2s_data, sample_req, underrun
  );
endinterface

// File: rtl/pcm_to_i2s_converter.sv
// pcm_to_i2s_converter: serializes L/R PCM words as an I2S master stream with divided bclk/lrclk
// clk: system clock; reset_n: synchronous active-low reset
// bus.l/r_din_valid + l/r_pcm_data: load holding registers; bus.bclk/lrclk/i2s_data: I2S stream
// bus.sample_req: frame-start strobe; bus.underrun: a channel was not refreshed since last frame start
module pcm_to_i2s_converter #(
  parameter int num_of_sample_bits = 24,
  parameter int slot_bits = 32,
  parameter int bclk_div = 4
) (
  input logic clk,
  input logic reset_n,
  pcm_to_i2s_converter_if.master bus
);
  localparam int pw = $clog2(2 * slot_bits);
  localparam int dw = $clog2(bclk_div);
  localparam logic [pw-1:0] pos_last = pw'(2 * slot_bits - 1);
  localparam logic [pw-1:0] slot_p = pw'(slot_bits);
  localparam logic [dw-1:0] div_last = dw'(bclk_div - 1);
  logic [dw-1:0] div_cnt;
  logic [pw-1:0] pos, pos_nxt, k_nxt;
  logic [num_of_sample_bits-1:0] l_hold, r_hold, l_word, r_word;
  logic [slot_bits-1:0] slot_sh;
  logic l_fresh, r_fresh, toggle, fall, frame_start, ch_nxt;
  // The slot is laid out as {0, word, zero pad}; shifting it left by k puts slot bit k at the MSB.
  always_comb begin
    toggle = div_cnt == div_last;
    fall = toggle && bus.bclk;
    pos_nxt = pos == pos_last ? '0 : pos + 1'b1;
    ch_nxt = pos_nxt >= slot_p;
    k_nxt = ch_nxt ? pos_nxt - slot_p : pos_nxt;
    frame_start = fall && pos_nxt == '0;
    slot_sh = slot_bits'({1'b0, ch_nxt ? r_word : l_word}) << (slot_bits - 1 - num_of_sample_bits);
    slot_sh = slot_sh << k_nxt;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt <= '0;
      pos <= pos_last;
      bus.bclk <= 1'b0;
      bus.lrclk <= 1'b1;
      bus.i2s_data <= 1'b0;
      bus.sample_req <= 1'b0;
      bus.underrun <= 1'b0;
      l_hold <= '0;
      r_hold <= '0;
      l_word <= '0;
      r_word <= '0;
      l_fresh <= 1'b0;
      r_fresh <= 1'b0;
    end else begin
      div_cnt <= toggle ? '0 : div_cnt + 1'b1;
      if (toggle) bus.bclk <= ~bus.bclk;
      if (fall) begin
        pos <= pos_nxt;
        bus.lrclk <= ch_nxt;
        bus.i2s_data <= slot_sh[slot_bits-1];
      end
      bus.sample_req <= frame_start;
      bus.underrun <= frame_start && !(l_fresh && r_fresh);
      if (frame_start) begin
        l_word <= l_hold;
        r_word <= r_hold;
      end
      if (bus.l_din_valid) l_hold <= bus.l_pcm_data;
      if (bus.r_din_valid) r_hold <= bus.r_pcm_data;
      // a strobe in the frame-start clk survives the clear
      l_fresh <= bus.l_din_valid || (l_fresh && !frame_start);
      r_fresh <= bus.r_din_valid || (r_fresh && !frame_start);
    end
  end
endmodule

// File: doc/pcm_to_i2s_converter.md
# pcm_to_i2s_converter

Transmit-side counterpart of the I2S capture path. It accepts left/right 24-bit PCM words from the processing chain through per-channel valid strobes and serializes them as an I2S master stream toward the DAC. It generates bclk and lrclk by dividing the system clock, and it signals when it wants the next sample pair and when it has had to repeat stale data.

## Interface
- num_of_sample_bits, 24: PCM word width; must be ≤ slot_bits-1.
- slot_bits, 32: bclk periods per channel slot; one frame is 2*slot_bits.
- bclk_div, 4: clk cycles per bclk half-period; must be ≥ 2.
- clk  in  1  system clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- l_din_valid  in  1  one-clk strobe that loads l_pcm_data into the left holding register.
- r_din_valid  in  1  one-clk strobe that loads r_pcm_data into the right holding register.
- l_pcm_data  in  num_of_sample_bits  left sample, two's complement.
- r_pcm_data  in  num_of_sample_bits  right sample, two's complement.
- bclk  out  1  I2S bit clock, registered.
- lrclk  out  1  word select: 0 = left slot, 1 = right slot; registered.
- i2s_data  out  1  serial data, MSB first; registered.
- sample_req  out  1  one-clk strobe at each frame start, requesting the next L/R pair.
- underrun  out  1  one-clk strobe, coincident with sample_req, when a channel had no new valid since the previous frame start.

## Operation
- **Divider.** div_cnt counts 0..bclk_div-1. When it reaches bclk_div-1, it wraps to 0 and bclk toggles.
  - The "fall event" is a toggle while bclk=1.
  - Rise events have no other effect.
- **Frame position.** pos counts 0..2*slot_bits-1 and advances by 1 on each fall event, wrapping to 0.
  - ch = pos/slot_bits.
  - k = pos mod slot_bits.
- **On each fall event:** lrclk ← ch of the new pos.
  - i2s_data ← frame_word[ch][num_of_sample_bits-k] for 1 ≤ k ≤ num_of_sample_bits.
  - i2s_data ← 0 for k = 0 and for k > num_of_sample_bits.
  - This gives standard I2S: the MSB appears one bclk after the lrclk edge, and lrclk and data change on the bclk falling edge.
- **Holding registers.** l_hold and r_hold load on their valid strobes. Each channel has a fresh flag that is set by its strobe.
- **Frame start** is the fall event where pos wraps to 0. In that clk:
  - frame_word[0] ← l_hold and frame_word[1] ← r_hold.
  - sample_req = 1.
  - underrun = 1 if either fresh flag was 0 before this clk.
  - Both fresh flags clear.
- **Valid strobe coincident with frame start.**
  - The frame copies the old hold value.
  - The hold register takes the new data.
  - That channel's fresh flag ends set, because set wins over clear.
  - underrun is evaluated on the pre-cycle flag.
- **Underrun behaviour.** The old hold value is retransmitted. Nothing is zeroed.
- **Mid-frame strobes.** Strobes arriving mid-frame never disturb the word being shifted out.
- **Multiple strobes.** Several strobes for one channel within a frame leave only the last value.

## Timing
- **Reset values** (reset_n=0 at a clk edge):
  - bclk=0, lrclk=1, i2s_data=0, sample_req=0, underrun=0.
  - div_cnt=0, pos=2*slot_bits-1.
  - l_hold, r_hold and frame words are 0; fresh flags are 0.
- **First edges after release.** With reset deasserted at edge 0:
  - bclk rises at edge bclk_div.
  - The first fall event is at edge 2*bclk_div. There pos=0, lrclk=0, and sample_req=1.
  - underrun=1 at that first frame start unless both channels were strobed beforehand.
- **Periods.**
  - bclk period = 2*bclk_div clk.
  - Frame period = 2*slot_bits*2*bclk_div clk (512 clk at defaults).
- **Latency.** A sample strobed at least 1 clk before a frame start has its MSB on i2s_data 2*bclk_div clk after that frame start (left channel). The right MSB follows slot_bits bclk periods later.
- **Reset mid-frame.** All state returns to reset values on the next edge. There is no partial-frame completion.
- **Outputs.** All outputs are registered, with no combinational path from inputs.

## Test plan
- **Reset release, no strobes:** bclk rises at clk 4 and falls at clk 8. At clk 8, sample_req=1, underrun=1, lrclk 1→0. i2s_data stays 0 for the whole frame.
- **Basic frame:** strobe L=24'hA5F00F and R=24'h5A0FF0 before a frame start. The captured bits are 1 zero, 24 data bits MSB-first, then 7 zeros per slot. lrclk is low for 32 bclks, then high. underrun=0.
- **Loopback:** feed the output into the I2S capture block. It recovers the exact L/R words for 8 consecutive random frames, with 1-frame transmit latency.
- **Strobe coincident with frame start:** the old word is transmitted this frame, the new word next frame, and no underrun is flagged at the next start.
- **Right-only starvation:** strobe only L each frame. underrun=1 at every start, and R repeats its last value unchanged.
- **Reset pulse at pos=40:** on the next edge, bclk=0, lrclk=1, i2s_data=0. The first fall event is at 8 clk after release.
